// File: rtl/controle_microondas_pkg.sv
// Shared state encodings and defaults for the microwave cooking-cycle controller.
package controle_microondas_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_COOK  = 3'd2,
      ST_PAUSE = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam int unsigned BEEP_CYCLES_DEF = 8;
   localparam int unsigned BEEP_W_DEF      = 8;

endpackage

// File: rtl/controle_microondas_temporizador_bip.sv
// End-of-cycle beep duration counter: synchronous clear, count enable, terminal-count flag.
module temporizador_bip #(
   parameter int unsigned TERM = 8,
   parameter int unsigned W    = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic count_i,
   output logic tc_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (count_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == W'(TERM - 1));

endmodule

// File: rtl/controle_microondas.sv
// Cooking-cycle control FSM driving the countdown timer and magnetron.
// Optional beep stretching in DONE is enabled with `define CONTROLE_BEEP_EN.
module controle_microondas
   import controle_microondas_pkg::*;
#(
   parameter int unsigned BEEP_CYCLES = BEEP_CYCLES_DEF,
   parameter int unsigned BEEP_W      = BEEP_W_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic stop_clear,
   input  logic door_closed,
   input  logic zero,
   output logic load,
   output logic enable,
   output logic mag_on,
   output logic done,
   output logic beep
);

   state_e state_q, state_d;
   logic   beep_tc;

`ifdef CONTROLE_BEEP_EN
   temporizador_bip #(
      .TERM (BEEP_CYCLES),
      .W    (BEEP_W)
   ) u_temporizador_bip (
      .clk_i   (clk),
      .rst_i   (reset),
      .clear_i (state_d != ST_DONE),
      .count_i (state_q == ST_DONE),
      .tc_o    (beep_tc)
   );
`else
   // Without the beep, DONE always lasts a single cycle.
   assign beep_tc = 1'b1;
   logic unused_cfg;
   assign unused_cfg = ^{BEEP_CYCLES, BEEP_W};
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start && door_closed) state_d = ST_LOAD;
         ST_LOAD:  state_d = ST_COOK;
         ST_COOK: begin
            if (!door_closed || stop_clear) state_d = ST_PAUSE;
            else if (zero)                  state_d = ST_DONE;
         end
         ST_PAUSE: begin
            if (stop_clear)                  state_d = ST_IDLE;
            else if (start && door_closed)   state_d = ST_COOK;
         end
         ST_DONE: begin
            if (stop_clear || !door_closed || beep_tc) state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Moore outputs decoded straight from the state register.
   always_comb begin
      load   = 1'b0;
      enable = 1'b0;
      mag_on = 1'b0;
      done   = 1'b0;
      beep   = 1'b0;
      unique case (state_q)
         ST_LOAD: load = 1'b1;
         ST_COOK: begin
            enable = 1'b1;
            mag_on = 1'b1;
         end
         ST_DONE: begin
            done = 1'b1;
`ifdef CONTROLE_BEEP_EN
            beep = 1'b1;
`endif
         end
         default: ;
      endcase
   end

endmodule
